// File: rtl/conv_relu_pool.sv
// conv_relu_pool: ReLU, rounding requantization and 2x2 stride-2 max pooling of conv results.
// Optional per-frame saturation counter port sat_cnt, enabled by `define CONV_RELU_POOL_SATCNT_EN.
module conv_relu_pool #(
  parameter int BITS  = 16,
  parameter int ACC_W = 37,
  parameter int SHIFT = 8,
  parameter int MAP_W = 26,
  parameter int MAP_H = 26
) (
  input  logic                    clk_in,
  input  logic                    rst_n,
  input  logic signed [ACC_W-1:0] data_in,
  input  logic                    valid_in,
  input  logic                    frame_sync,
  output logic        [BITS-1:0]  data_out,
  output logic                    ready,
`ifdef CONV_RELU_POOL_SATCNT_EN
  output logic                    frame_done,
  output logic        [15:0]      sat_cnt
`else
  output logic                    frame_done
`endif
);

  localparam int CW  = $clog2(MAP_W) + 1;
  localparam int RW  = $clog2(MAP_H) + 1;
  localparam int LIW = ($clog2(MAP_W / 2) > 0) ? $clog2(MAP_W / 2) : 1;
  localparam logic [ACC_W:0] RND  = ({{ACC_W{1'b0}}, 1'b1} << SHIFT) >> 1;
  localparam logic [ACC_W:0] QMAX = ({{ACC_W{1'b0}}, 1'b1} << (BITS - 1)) - 1'b1;

  logic [CW-1:0]   col, eff_col, nxt_col;
  logic [RW-1:0]   row, eff_row, nxt_row;
  logic            last_px;
  logic [ACC_W:0]  rnd_sum, rnd_val;
  logic [BITS-1:0] q;

  logic            s1_valid, s1_row_odd, s1_col_odd, s1_last;
  logic [LIW-1:0]  s1_lidx;
  logic [BITS-1:0] s1_q, h_max;
  logic [BITS-1:0] pair_max, lb_rd, top_max;
  logic [BITS-1:0] lbuf [2**LIW];

  // A frame_sync alongside a sample makes that sample pixel (0,0).
  always_comb begin
    eff_col = frame_sync ? '0 : col;
    eff_row = frame_sync ? '0 : row;
    last_px = (eff_col == CW'(MAP_W - 1)) && (eff_row == RW'(MAP_H - 1));
    nxt_col = (eff_col == CW'(MAP_W - 1)) ? '0 : eff_col + 1'b1;
    nxt_row = eff_row;
    if (eff_col == CW'(MAP_W - 1))
      nxt_row = (eff_row == RW'(MAP_H - 1)) ? '0 : eff_row + 1'b1;
  end

  // One extra headroom bit keeps the rounding add from overflowing.
  always_comb begin
    rnd_sum = {1'b0, data_in} + RND;
    rnd_val = rnd_sum >> SHIFT;
    if (data_in[ACC_W-1])
      q = '0;
    else if (rnd_val > QMAX)
      q = QMAX[BITS-1:0];
    else
      q = rnd_val[BITS-1:0];
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_q       <= '0;
      s1_row_odd <= 1'b0;
      s1_col_odd <= 1'b0;
      s1_lidx    <= '0;
      s1_last    <= 1'b0;
      col        <= '0;
      row        <= '0;
    end else begin
      s1_valid <= valid_in;
      if (valid_in) begin
        s1_q       <= q;
        s1_row_odd <= eff_row[0];
        s1_col_odd <= eff_col[0];
        s1_lidx    <= eff_col[LIW:1];
        s1_last    <= last_px;
        col        <= nxt_col;
        row        <= nxt_row;
      end else if (frame_sync) begin
        col <= '0;
        row <= '0;
      end
    end
  end

  always_comb begin
    lb_rd    = lbuf[s1_lidx];
    pair_max = (s1_q > h_max) ? s1_q : h_max;
    top_max  = (lb_rd > pair_max) ? lb_rd : pair_max;
  end

  // Line buffer holds the top-row pair maxima; never reset, always written before read.
  always_ff @(posedge clk_in) begin
    if (s1_valid && !s1_row_odd && s1_col_odd)
      lbuf[s1_lidx] <= pair_max;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      data_out   <= '0;
      ready      <= 1'b0;
      frame_done <= 1'b0;
      h_max      <= '0;
    end else begin
      ready      <= s1_valid && s1_row_odd && s1_col_odd;
      frame_done <= s1_valid && s1_last;
      if (s1_valid && s1_row_odd && s1_col_odd)
        data_out <= top_max;
      if (frame_sync && !valid_in)
        h_max <= '0;
      else if (s1_valid && !s1_col_odd)
        h_max <= s1_q;
    end
  end

`ifdef CONV_RELU_POOL_SATCNT_EN
  logic sat_hit;
  assign sat_hit = valid_in && !data_in[ACC_W-1] && (rnd_val > QMAX);

  // Restarts per frame; a saturating sample on the restart cycle counts as the first.
  always_ff @(posedge clk_in) begin
    if (!rst_n)
      sat_cnt <= '0;
    else if (frame_sync || frame_done)
      sat_cnt <= {15'd0, sat_hit};
    else if (sat_hit && (sat_cnt != 16'hFFFF))
      sat_cnt <= sat_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_conv_relu_pool.sv
// Self-checking bench for conv_relu_pool: 2x2, 3x3 (SHIFT=0) and 26x26 instances on shared inputs,
// each phase realigned with frame_sync; expected values come from a frame-level reference model.
module tb_conv_relu_pool;

  localparam int AW = 37;

  logic                 clk_in = 1'b0;
  logic                 rst_n;
  logic signed [AW-1:0] data_in;
  logic                 valid_in;
  logic                 frame_sync;

  logic [15:0] out2, out3, out26;
  logic        rdy2, rdy3, rdy26, fd2, fd3, fd26;
`ifdef CONV_RELU_POOL_SATCNT_EN
  logic [15:0] sat2, sat3, sat26;
  logic [15:0] sat2AtRdy, sat3AtFd, sat26AtFd;
`endif

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int lastDriveCyc;

  logic [15:0] q2[$], q3[$], q26[$];
  int rdy2Cyc, fd2Cyc, fd2Cnt, rdy3Cyc, fd3Cyc, fd3Cnt, fd26Cnt;

  longint frm [26][26];

  typedef struct {
    longint x0, x1, x2, x3;
    longint expOut;
    longint expSat;
  } vec2_t;
  vec2_t vecs [8];

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  conv_relu_pool #(.MAP_W(2), .MAP_H(2)) dut2 (
    .clk_in(clk_in), .rst_n(rst_n), .data_in(data_in), .valid_in(valid_in),
    .frame_sync(frame_sync), .data_out(out2), .ready(rdy2), .frame_done(fd2)
`ifdef CONV_RELU_POOL_SATCNT_EN
    , .sat_cnt(sat2)
`endif
  );

  conv_relu_pool #(.SHIFT(0), .MAP_W(3), .MAP_H(3)) dut3 (
    .clk_in(clk_in), .rst_n(rst_n), .data_in(data_in), .valid_in(valid_in),
    .frame_sync(frame_sync), .data_out(out3), .ready(rdy3), .frame_done(fd3)
`ifdef CONV_RELU_POOL_SATCNT_EN
    , .sat_cnt(sat3)
`endif
  );

  conv_relu_pool dut26 (
    .clk_in(clk_in), .rst_n(rst_n), .data_in(data_in), .valid_in(valid_in),
    .frame_sync(frame_sync), .data_out(out26), .ready(rdy26), .frame_done(fd26)
`ifdef CONV_RELU_POOL_SATCNT_EN
    , .sat_cnt(sat26)
`endif
  );

  // Output monitor, sampled on the falling edge.
  always @(negedge clk_in) begin
    if (rdy2) begin
      q2.push_back(out2);
      rdy2Cyc = cyc;
`ifdef CONV_RELU_POOL_SATCNT_EN
      sat2AtRdy = sat2;
`endif
    end
    if (fd2) begin
      fd2Cnt++;
      fd2Cyc = cyc;
    end
    if (rdy3) begin
      q3.push_back(out3);
      rdy3Cyc = cyc;
    end
    if (fd3) begin
      fd3Cnt++;
      fd3Cyc = cyc;
`ifdef CONV_RELU_POOL_SATCNT_EN
      sat3AtFd = sat3;
`endif
    end
    if (rdy26) q26.push_back(out26);
    if (fd26) begin
      fd26Cnt++;
`ifdef CONV_RELU_POOL_SATCNT_EN
      sat26AtFd = sat26;
`endif
    end
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input longint x, input bit v, input bit fs);
    data_in      = x[AW-1:0];
    valid_in     = v;
    frame_sync   = fs;
    lastDriveCyc = cyc;
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(0, 1'b0, 1'b0);
  endtask

  // Reference: ReLU, round-half-up divide by 2^sh, clamp to 32767.
  function automatic longint quant(input longint x, input int sh);
    longint r;
    if (x < 0) return 0;
    r = (x + ((longint'(1) << sh) / 2)) / (longint'(1) << sh);
    return (r > 32767) ? 32767 : r;
  endfunction

  function automatic bit isSat(input longint x, input int sh);
    if (x < 0) return 1'b0;
    return ((x + ((longint'(1) << sh) / 2)) / (longint'(1) << sh)) > 32767;
  endfunction

  function automatic longint poolAt(input int i, input int j);
    longint m = 0;
    for (int a = 0; a < 2; a++)
      for (int b = 0; b < 2; b++)
        if (quant(frm[2*i+a][2*j+b], 8) > m) m = quant(frm[2*i+a][2*j+b], 8);
    return m;
  endfunction

  function automatic longint randVal();
    int sel = $urandom_range(0, 9);
    case (sel)
      0, 1:    return -longint'($urandom_range(0, 1 << 30));
      2:       return longint'($urandom_range(0, 255)) << 20;
      3:       return (longint'(1) << 36) - 1;
      4:       return -(longint'(1) << 36);
      default: return longint'($urandom_range(0, 1 << 23));
    endcase
  endfunction

  task automatic fillRandom();
    for (int i = 0; i < 26; i++)
      for (int j = 0; j < 26; j++)
        frm[i][j] = randVal();
  endtask

  task automatic feedFrame(input int count, input bit syncFirst);
    for (int k = 0; k < count; k++) begin
      repeat ($urandom_range(0, 3)) applyStimulus(0, 1'b0, 1'b0);
      applyStimulus(frm[k/26][k%26], 1'b1, syncFirst && (k == 0));
    end
  endtask

  task automatic checkFrame(input string name, input bit hasOld, input longint oldVal);
    checkOutput($sformatf("%s count", name), q26.size(), 169 + (hasOld ? 1 : 0));
    checkOutput($sformatf("%s frame_done", name), fd26Cnt, 1);
    if (hasOld && q26.size() > 0)
      checkOutput($sformatf("%s inflight", name), q26.pop_front(), oldVal);
    for (int i = 0; i < 13; i++)
      for (int j = 0; j < 13; j++)
        if (q26.size() > 0)
          checkOutput($sformatf("%s w(%0d,%0d)", name, i, j), q26.pop_front(), poolAt(i, j));
  endtask

  task automatic partialThenRestart(input string name, input int mode);
    longint oldVal;
    applyStimulus(0, 1'b0, 1'b1);
    fillRandom();
    feedFrame(5 * 26 + 12, 1'b0);
    oldVal = poolAt(2, 5);
    q26.delete();
    fd26Cnt = 0;
    if (mode == 0) begin
      rst_n = 1'b0;
      applyStimulus(0, 1'b0, 1'b0);
      rst_n = 1'b1;
      checkOutput($sformatf("%s data_out after reset", name), out26, 0);
      fillRandom();
      feedFrame(676, 1'b0);
    end else if (mode == 1) begin
      applyStimulus(0, 1'b0, 1'b1);
      fillRandom();
      feedFrame(676, 1'b0);
    end else begin
      fillRandom();
      feedFrame(676, 1'b1);
    end
    idle(5);
    checkFrame(name, mode != 0, oldVal);
  endtask

  initial begin
    longint v3 [9];
    longint exp3;
    int c4, c5, c9, satExp;

    vecs[0] = '{256, 512, 768, 1024, 4, 0};
    vecs[1] = '{-5000, -5000, -5000, -5000, 0, 0};
    vecs[2] = '{383, 0, 0, 0, 1, 0};
    vecs[3] = '{384, 0, 0, 0, 2, 0};
    vecs[4] = '{longint'(1) << 30, 0, 0, 0, 32767, 1};
    vecs[5] = '{127, 128, -1, 0, 1, 0};
    vecs[6] = '{0, 0, 0, 8388479, 32767, 0};
    vecs[7] = '{8388480, -(longint'(1) << 36), (longint'(1) << 36) - 1, 0, 32767, 2};

    rst_n = 1'b0;
    data_in = '0;
    valid_in = 1'b0;
    frame_sync = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    checkOutput("reset data_out2", out2, 0);
    checkOutput("reset ready2", rdy2, 0);
    checkOutput("reset frame_done2", fd2, 0);
    checkOutput("reset ready3", rdy3, 0);
    checkOutput("reset ready26", rdy26, 0);
    checkOutput("reset frame_done26", fd26, 0);
    rst_n = 1'b1;
    idle(2);

    $display("[TB] 2x2 vector table");
    for (int v = 0; v < 8; v++) begin
      applyStimulus(0, 1'b0, 1'b1);
      idle(1);
      q2.delete();
      fd2Cnt = 0;
      applyStimulus(vecs[v].x0, 1'b1, 1'b0);
      applyStimulus(vecs[v].x1, 1'b1, 1'b0);
      applyStimulus(vecs[v].x2, 1'b1, 1'b0);
      applyStimulus(vecs[v].x3, 1'b1, 1'b0);
      c4 = lastDriveCyc;
      idle(4);
      checkOutput($sformatf("v%0d ready count", v), q2.size(), 1);
      if (q2.size() > 0)
        checkOutput($sformatf("v%0d data_out", v), q2.pop_front(), vecs[v].expOut);
      checkOutput($sformatf("v%0d ready latency", v), rdy2Cyc, c4 + 2);
      checkOutput($sformatf("v%0d frame_done cycle", v), fd2Cyc, c4 + 2);
      checkOutput($sformatf("v%0d frame_done count", v), fd2Cnt, 1);
`ifdef CONV_RELU_POOL_SATCNT_EN
      checkOutput($sformatf("v%0d sat_cnt", v), sat2AtRdy, vecs[v].expSat);
`endif
    end

    $display("[TB] 3x3 SHIFT=0 frame");
    applyStimulus(0, 1'b0, 1'b1);
    q3.delete();
    fd3Cnt = 0;
    satExp = 0;
    for (int k = 0; k < 9; k++) begin
      v3[k] = longint'($urandom_range(0, 1 << 18)) - (longint'(1) << 17);
      if (isSat(v3[k], 0)) satExp++;
      repeat ($urandom_range(0, 2)) applyStimulus(0, 1'b0, 1'b0);
      applyStimulus(v3[k], 1'b1, 1'b0);
      if (k == 4) c5 = lastDriveCyc;
      if (k == 8) c9 = lastDriveCyc;
    end
    idle(5);
    exp3 = quant(v3[0], 0);
    if (quant(v3[1], 0) > exp3) exp3 = quant(v3[1], 0);
    if (quant(v3[3], 0) > exp3) exp3 = quant(v3[3], 0);
    if (quant(v3[4], 0) > exp3) exp3 = quant(v3[4], 0);
    checkOutput("3x3 ready count", q3.size(), 1);
    if (q3.size() > 0) checkOutput("3x3 data_out", q3.pop_front(), exp3);
    checkOutput("3x3 ready latency", rdy3Cyc, c5 + 2);
    checkOutput("3x3 frame_done cycle", fd3Cyc, c9 + 2);
    checkOutput("3x3 frame_done count", fd3Cnt, 1);
`ifdef CONV_RELU_POOL_SATCNT_EN
    checkOutput("3x3 sat_cnt", sat3AtFd, satExp);
`endif

    $display("[TB] 26x26 ramp frame");
    applyStimulus(0, 1'b0, 1'b1);
    q26.delete();
    fd26Cnt = 0;
    for (int i = 0; i < 26; i++)
      for (int j = 0; j < 26; j++)
        frm[i][j] = longint'((i * 26 + j) * 256);
    feedFrame(676, 1'b0);
    idle(5);
    if (q26.size() > 0) checkOutput("ramp first window", q26[0], 27);
    checkFrame("ramp", 1'b0, 0);
`ifdef CONV_RELU_POOL_SATCNT_EN
    checkOutput("ramp sat_cnt", sat26AtFd, 0);
`endif

    $display("[TB] 26x26 random frame");
    applyStimulus(0, 1'b0, 1'b1);
    q26.delete();
    fd26Cnt = 0;
    fillRandom();
    satExp = 0;
    for (int i = 0; i < 26; i++)
      for (int j = 0; j < 26; j++)
        if (isSat(frm[i][j], 8)) satExp++;
    feedFrame(676, 1'b0);
    idle(5);
    checkFrame("random", 1'b0, 0);
`ifdef CONV_RELU_POOL_SATCNT_EN
    checkOutput("random sat_cnt", sat26AtFd, satExp);
`endif

    $display("[TB] mid-frame restart sequences");
    partialThenRestart("reset restart", 0);
    partialThenRestart("sync restart", 1);
    partialThenRestart("sync+valid restart", 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_relu_pool.md
Name: conv_relu_pool

Overview:
- Downstream stage of the convolution MAC. Consumes one wide signed accumulator result per `ready` pulse from the conv unit.
- Per sample: ReLU, rounding right-shift requantization and saturation back to BITS.
- Then 2x2 stride-2 max pooling over a raster-ordered feature map, using an internal half-row line buffer.
- Emits one pooled pixel per 2x2 window, with a one-cycle `ready` pulse to the next layer.

Parameters:
- BITS, 16, output feature width (signed container, always non-negative after ReLU).
- ACC_W, 37, input accumulator width (2*BITS + 4 + 1, matching the conv output).
- SHIFT, 8, requantization right-shift amount (0 allowed).
- MAP_W, 26, conv output map width in pixels (2..1024).
- MAP_H, 26, conv output map height in rows (2..1024).

Ports:
- clk_in  input  1  system clock, rising edge.
- rst_n  input  1  reset; one clock; reset is synchronous and active-low.
- data_in  input  ACC_W  signed conv result.
- valid_in  input  1  data_in valid this cycle (driven by conv `ready`).
- frame_sync  input  1  restarts raster position at (row 0, col 0).
- data_out  output  BITS  pooled, requantized pixel.
- ready  output  1  one-cycle pulse, data_out valid.
- frame_done  output  1  one-cycle pulse, end of frame.

Behaviour:
- Reset (synchronous, rst_n low at a clk_in edge):
  - data_out=0, ready=0, frame_done=0.
  - row/col counters=0, h_max=0, pipeline valids=0.
  - Line buffer is not cleared; it is always written on an even row before it is read.
  - Reset mid-frame discards the partial frame; the next valid_in is pixel (0,0).
- Stage 1 (registered, on valid_in):
  - x<0 -> q=0.
  - Otherwise r=(x + (SHIFT>0 ? 1<<(SHIFT-1) : 0)) >>> SHIFT, i.e. round half up, computed at ACC_W+1 bits with no overflow.
  - r > 2^(BITS-1)-1 -> q=2^(BITS-1)-1 (saturate); else q=r.
  - Stage 1 also registers the (row, col) tag of the sample.
- Stage 2 (pool, on stage-1 valid):
  - Even row, even col: h_max<=q.
  - Even row, odd col: lbuf[col>>1]<=max(h_max,q).
  - Odd row, even col: h_max<=q.
  - Odd row, odd col: data_out<=max(lbuf[col>>1],h_max,q); ready<=1 for one cycle.
- Latency: ready rises exactly 2 cycles after the valid_in edge of the window's bottom-right pixel.
- Throughput: valid_in may be asserted every cycle; gaps of any length are allowed, and all state holds while valid_in=0.
- Odd MAP_W: last column is consumed but never pooled (floor). Odd MAP_H: last row is consumed with no output.
- Counters: col wraps MAP_W-1->0 and increments row; row wraps MAP_H-1->0.
- frame_done pulses 2 cycles after valid_in of pixel (MAP_H-1, MAP_W-1). It coincides with the last ready when both dimensions are even.
- frame_sync:
  - With valid_in in the same cycle: the sample is treated as (0,0).
  - Alone: counters and h_max clear; in-flight stage-1/stage-2 results still complete.
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: CONV_RELU_POOL_SATCNT_EN.
- When defined:
  - Adds output port sat_cnt [15:0], the count of stage-1 samples that saturated in the current frame.
  - Saturates at 16'hFFFF.
  - Cleared on reset and on frame_sync.
  - Reloaded to 0 (or 1 if the cycle also saturates) on the cycle after frame_done.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- MAP_W=MAP_H=2, SHIFT=8, inputs 256,512,768,1024 on consecutive cycles -> single ready, data_out=4, 2 cycles after the 4th valid_in; frame_done same cycle.
- 2x2, all inputs -5000 -> data_out=0. Inputs 383,0,0,0 -> data_out=1. Inputs 384,0,0,0 -> data_out=2 (round half up).
- 2x2, input 2^30 plus three zeros -> data_out=32767; sat_cnt=1 when CONV_RELU_POOL_SATCNT_EN.
- Default 26x26, x=(row*26+col)*256, valid_in with random 0-3 cycle gaps -> exactly 169 ready pulses, window (i,j) gives data_out=(2i+1)*26+2j+1; one frame_done.
- MAP_W=MAP_H=3, 9 samples -> 1 ready (top-left window only); frame_done after 9th sample +2 cycles.
- 26x26 with rst_n low for 1 cycle mid-row 5, then a new full frame -> exactly 169 outputs, all matching the new frame. Repeat with frame_sync instead of reset -> same result.
